// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared types for the prefetching fetch stage. Holds the fetch
//               FSM encoding, the instruction size in bytes used to step the
//               fetch PC, and the default-width prefetch queue entry.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    // Bytes per instruction; the fetch PC advances by this on every accepted read.
    localparam int unsigned INSTR_BYTES = 4;

    // IDLE : no cache read outstanding
    // REQ  : read outstanding, its response will be queued
    // DROP : read outstanding, its response belongs to a flushed path
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } fetch_state_e;

    // Queue entry for the default 32-bit core configuration. The top level
    // declares an equivalent entry sized from its own parameters.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fetch_fifo
// Description : Synchronous FIFO with single-cycle flush, used as the
//               prefetch queue. Head data reads as zero while empty.
// Ports       : i_clk       - clock, all state on rising edge
//               i_rst       - synchronous reset, active-low
//               i_flush     - empty the queue (overrides push/pop)
//               i_push      - write i_push_data at the tail
//               i_push_data - entry to write
//               i_pop       - drop the head entry
//               o_head      - head entry, zero when empty
//               o_count     - number of stored entries
//               o_empty     - no entries stored
//               o_full      - DEPTH entries stored
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_flush,
    input  logic                         i_push,
    input  logic [WIDTH-1:0]             i_push_data,
    input  logic                         i_pop,
    output logic [WIDTH-1:0]             o_head,
    output logic [$clog2(DEPTH+1)-1:0]   o_count,
    output logic                         o_empty,
    output logic                         o_full
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    assign o_count = r_count;
    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CNT_W'(DEPTH));

    // A pop on empty is ignored; a push on full only lands alongside a pop.
    assign w_pop  = i_pop && !o_empty;
    assign w_push = i_push && (!o_full || w_pop);

    assign o_head = o_empty ? '0 : r_mem[r_rd_ptr];

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge i_clk) begin
        if (!i_rst || i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    // Storage needs no reset: entries are only visible through the count.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fetch_prefetch.sv
`default_nettype none
// ============================================================================
// Module      : fetch_prefetch
// Description : Prefetching instruction fetch stage. Issues sequential
//               I-cache reads ahead of decode into a DEPTH-entry queue of
//               {pc, instr} pairs; a redirect flushes the queue and discards
//               any response still in flight.
// Ports       : i_clk          - clock
//               i_rst          - synchronous reset, active-low
//               i_stall        - decode does not take the head this cycle
//               i_branch_taken - redirect to i_target_pc
//               i_target_pc    - redirect address
//               i_instr        - cache read data (valid with i_icache_done)
//               i_icache_done  - cache completes the outstanding read
//               o_instr_rd     - cache read strobe, held until done
//               o_icache_addr  - cache read address
//               o_instr        - head instruction (0 when empty)
//               o_pc           - head PC (0 when empty)
//               o_instr_ready  - queue non-empty
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_prefetch
    import fetch_pkg::*;
#(
    parameter int unsigned              ADDRESS_WIDTH = 32,
    parameter int unsigned              INSTR_WIDTH   = 32,
    parameter int unsigned              DEPTH         = 4,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = '0
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_stall,
    input  logic                     i_branch_taken,
    input  logic [ADDRESS_WIDTH-1:0] i_target_pc,
    input  logic [INSTR_WIDTH-1:0]   i_instr,
    input  logic                     i_icache_done,
    output logic                     o_instr_rd,
    output logic [ADDRESS_WIDTH-1:0] o_icache_addr,
    output logic [INSTR_WIDTH-1:0]   o_instr,
    output logic [ADDRESS_WIDTH-1:0] o_pc,
    output logic                     o_instr_ready
);

    localparam int unsigned CNT_W   = $clog2(DEPTH + 1);
    localparam int unsigned ENTRY_W = ADDRESS_WIDTH + INSTR_WIDTH;

    typedef struct packed {
        logic [ADDRESS_WIDTH-1:0] pc;
        logic [INSTR_WIDTH-1:0]   instr;
    } entry_t;

    fetch_state_e             r_state;
    fetch_state_e             w_next_state;
    logic [ADDRESS_WIDTH-1:0] r_fpc;
    logic [ADDRESS_WIDTH-1:0] w_next_fpc;
    logic [ADDRESS_WIDTH-1:0] r_addr;
    logic [ADDRESS_WIDTH-1:0] w_next_addr;
    logic [ADDRESS_WIDTH-1:0] w_fpc_inc;

    logic                     w_pop;
    logic                     w_push;
    logic                     w_push_ok;
    logic                     w_flush;
    logic                     w_issue;
    logic [CNT_W-1:0]         w_count;
    logic [CNT_W-1:0]         w_count_after;
    logic                     w_empty;
    logic                     w_full;
    entry_t                   w_push_entry;
    entry_t                   w_head;
    logic [ENTRY_W-1:0]       w_head_raw;

    // ------------------------------------------------------------------
    // Queue
    // ------------------------------------------------------------------
    assign w_push_entry.pc    = r_addr;
    assign w_push_entry.instr = i_instr;
    assign w_head             = entry_t'(w_head_raw);

    // Slot reservation already prevents a push into a full queue without a
    // pop; the extra gate keeps the queue safe if that invariant is broken.
    assign w_push_ok = w_push && (!w_full || w_pop);

    fetch_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_queue (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_flush     (w_flush),
        .i_push      (w_push_ok),
        .i_push_data (w_push_entry),
        .i_pop       (w_pop),
        .o_head      (w_head_raw),
        .o_count     (w_count),
        .o_empty     (w_empty),
        .o_full      (w_full)
    );

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_flush      = i_branch_taken;
        w_pop        = !w_empty && !i_stall && !i_branch_taken;
        w_push       = (r_state == REQ) && i_icache_done && !i_branch_taken;
        // Occupancy once this cycle's pop and push settle. A new read is only
        // issued while this leaves room, so every outstanding read owns a slot.
        w_count_after = w_count + CNT_W'(w_push) - CNT_W'(w_pop);
        w_issue      = (w_count_after < CNT_W'(DEPTH));
        w_fpc_inc    = r_fpc + ADDRESS_WIDTH'(INSTR_BYTES);

        w_next_state = r_state;
        w_next_fpc   = r_fpc;
        w_next_addr  = r_addr;

        if (i_branch_taken) begin
            w_next_fpc = i_target_pc;
            if ((r_state != IDLE) && !i_icache_done) begin
                // Old read still pending: keep presenting it until it ends.
                w_next_state = DROP;
            end else begin
                w_next_state = REQ;
                w_next_addr  = i_target_pc;
            end
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_issue) begin
                        w_next_state = REQ;
                        w_next_addr  = r_fpc;
                    end
                end
                REQ: begin
                    if (i_icache_done) begin
                        w_next_fpc = w_fpc_inc;
                        if (w_issue) begin
                            w_next_addr = w_fpc_inc;
                        end else begin
                            w_next_state = IDLE;
                        end
                    end
                end
                DROP: begin
                    // The queue is empty after the flush, so a slot is free.
                    if (i_icache_done) begin
                        w_next_state = REQ;
                        w_next_addr  = r_fpc;
                    end
                end
                default: begin
                    w_next_state = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state <= IDLE;
            r_fpc   <= RESET_PC;
            r_addr  <= RESET_PC;
        end else begin
            r_state <= w_next_state;
            r_fpc   <= w_next_fpc;
            r_addr  <= w_next_addr;
        end
    end

    // ------------------------------------------------------------------
    // Outputs (registers and queue state only)
    // ------------------------------------------------------------------
    assign o_instr_rd    = (r_state != IDLE);
    assign o_icache_addr = r_addr;
    assign o_instr       = w_head.instr;
    assign o_pc          = w_head.pc;
    assign o_instr_ready = !w_empty;

endmodule
`default_nettype wire

// File: tb/tb_fetch_prefetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_prefetch
// Description : Self-checking bench for fetch_prefetch: a vector table for
//               stream/backpressure, hand-written redirect and reset
//               sequences, a wrap-around instance, and a randomized run
//               checked against a program-order reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_prefetch;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        stall;
    logic        br;
    logic        done;
    logic [31:0] target;
    logic [31:0] instr;
    logic        o_rd;
    logic [31:0] o_addr;
    logic [31:0] o_instr;
    logic [31:0] o_pc;
    logic        o_rdy;

    logic [31:0] key;
    int          compared   = 0;
    int          mismatched = 0;

    fetch_prefetch #(
        .ADDRESS_WIDTH (32),
        .INSTR_WIDTH   (32),
        .DEPTH         (4),
        .RESET_PC      (32'h0)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_stall        (stall),
        .i_branch_taken (br),
        .i_target_pc    (target),
        .i_instr        (instr),
        .i_icache_done  (done),
        .o_instr_rd     (o_rd),
        .o_icache_addr  (o_addr),
        .o_instr        (o_instr),
        .o_pc           (o_pc),
        .o_instr_ready  (o_rdy)
    );

    // Second instance for the address wrap case: cache always completes and
    // returns the address as data.
    logic        rst_w;
    logic        rd_w;
    logic [31:0] addr_w;
    logic [31:0] instr_w;
    logic [31:0] pc_w;
    logic        rdy_w;

    fetch_prefetch #(
        .ADDRESS_WIDTH (32),
        .INSTR_WIDTH   (32),
        .DEPTH         (4),
        .RESET_PC      (32'hFFFF_FFF8)
    ) dut_wrap (
        .i_clk          (clk),
        .i_rst          (rst_w),
        .i_stall        (1'b0),
        .i_branch_taken (1'b0),
        .i_target_pc    (32'h0),
        .i_instr        (addr_w),
        .i_icache_done  (1'b1),
        .o_instr_rd     (rd_w),
        .o_icache_addr  (addr_w),
        .o_instr        (instr_w),
        .o_pc           (pc_w),
        .o_instr_ready  (rdy_w)
    );

    typedef struct {
        logic        rst;
        logic        stall;
        logic        done;
        logic        br;
        logic [31:0] tgt;
        logic        e_rd;
        logic [31:0] e_addr;
        logic        e_rdy;
        logic [31:0] e_pc;
    } vec_t;

    vec_t tbl [20];

    function automatic vec_t v(input logic r, input logic s, input logic d,
                               input logic b, input logic [31:0] t,
                               input logic erd, input logic [31:0] ea,
                               input logic erdy, input logic [31:0] ep);
        vec_t x;
        x.rst = r; x.stall = s; x.done = d; x.br = b; x.tgt = t;
        x.e_rd = erd; x.e_addr = ea; x.e_rdy = erdy; x.e_pc = ep;
        return x;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Cache model: the response data for an address is address ^ key.
    task automatic drive(input logic r, input logic s, input logic d,
                         input logic b, input logic [31:0] t);
        rst = r; stall = s; done = d; br = b; target = t;
        instr = o_addr ^ key;
    endtask

    task automatic obs(input string tag, input logic e_rd, input logic [31:0] e_addr,
                       input logic e_rdy, input logic [31:0] e_pc);
        chk({tag, ".rd"},    o_rd,    e_rd);
        chk({tag, ".addr"},  o_addr,  e_addr);
        chk({tag, ".ready"}, o_rdy,   e_rdy);
        chk({tag, ".pc"},    o_pc,    e_pc);
        chk({tag, ".instr"}, o_instr, e_rdy ? (e_pc ^ key) : 32'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_pc;
        logic [31:0] prev_addr;
        logic        prev_rd;
        logic        prev_done;
        logic        s;
        logic        d;
        logic        b;
        logic [31:0] t;
        int          consumed;

        key   = 32'h0;
        rst_w = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

        // ---------------- stream + backpressure vector table -------------
        //             rst stall done br tgt    rd addr rdy pc
        tbl[0]  = v(1'b0,1'b0,1'b0,1'b0,32'h0, 1'b0,32'd0, 1'b0,32'd0);
        tbl[1]  = v(1'b1,1'b0,1'b0,1'b0,32'h0, 1'b0,32'd0, 1'b0,32'd0);
        tbl[2]  = v(1'b1,1'b0,1'b1,1'b0,32'h0, 1'b1,32'd0, 1'b0,32'd0);
        tbl[3]  = v(1'b1,1'b0,1'b1,1'b0,32'h0, 1'b1,32'd4, 1'b1,32'd0);
        tbl[4]  = v(1'b1,1'b0,1'b1,1'b0,32'h0, 1'b1,32'd8, 1'b1,32'd4);
        tbl[5]  = v(1'b1,1'b0,1'b1,1'b0,32'h0, 1'b1,32'd12,1'b1,32'd8);
        tbl[6]  = v(1'b1,1'b0,1'b0,1'b0,32'h0, 1'b1,32'd16,1'b1,32'd12);
        tbl[7]  = v(1'b0,1'b0,1'b0,1'b0,32'h0, 1'b1,32'd16,1'b0,32'd0);
        tbl[8]  = v(1'b1,1'b1,1'b0,1'b0,32'h0, 1'b0,32'd0, 1'b0,32'd0);
        tbl[9]  = v(1'b1,1'b1,1'b1,1'b0,32'h0, 1'b1,32'd0, 1'b0,32'd0);
        tbl[10] = v(1'b1,1'b1,1'b1,1'b0,32'h0, 1'b1,32'd4, 1'b1,32'd0);
        tbl[11] = v(1'b1,1'b1,1'b1,1'b0,32'h0, 1'b1,32'd8, 1'b1,32'd0);
        tbl[12] = v(1'b1,1'b1,1'b1,1'b0,32'h0, 1'b1,32'd12,1'b1,32'd0);
        tbl[13] = v(1'b1,1'b1,1'b1,1'b0,32'h0, 1'b0,32'd12,1'b1,32'd0);
        tbl[14] = v(1'b1,1'b0,1'b0,1'b0,32'h0, 1'b0,32'd12,1'b1,32'd0);
        tbl[15] = v(1'b1,1'b0,1'b1,1'b0,32'h0, 1'b1,32'd16,1'b1,32'd4);
        tbl[16] = v(1'b1,1'b0,1'b0,1'b0,32'h0, 1'b1,32'd20,1'b1,32'd8);
        tbl[17] = v(1'b1,1'b0,1'b0,1'b0,32'h0, 1'b1,32'd20,1'b1,32'd12);
        tbl[18] = v(1'b1,1'b0,1'b0,1'b0,32'h0, 1'b1,32'd20,1'b1,32'd16);
        tbl[19] = v(1'b1,1'b0,1'b0,1'b0,32'h0, 1'b1,32'd20,1'b0,32'd0);

        tick();
        tick();
        for (int i = 0; i < 20; i++) begin
            obs($sformatf("vec%0d", i), tbl[i].e_rd, tbl[i].e_addr, tbl[i].e_rdy, tbl[i].e_pc);
            drive(tbl[i].rst, tbl[i].stall, tbl[i].done, tbl[i].br, tbl[i].tgt);
            tick();
        end

        // ---------------- redirect while read of 0x8 is in flight --------
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0); tick();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0); tick();
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0); tick();
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0); tick();
        obs("pre_redirect", 1'b1, 32'h8, 1'b1, 32'h0);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h100); tick();
        obs("drop0", 1'b1, 32'h8, 1'b0, 32'h0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0); tick();
        obs("drop1", 1'b1, 32'h8, 1'b0, 32'h0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0); tick();
        obs("drop2", 1'b1, 32'h8, 1'b0, 32'h0);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0); tick();
        obs("after_drop", 1'b1, 32'h100, 1'b0, 32'h0);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0); tick();
        obs("target_head", 1'b1, 32'h104, 1'b1, 32'h100);

        // ---------------- redirect coincident with done ------------------
        drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h40); tick();
        obs("coinc_redirect", 1'b1, 32'h40, 1'b0, 32'h0);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0); tick();
        obs("coinc_head", 1'b1, 32'h44, 1'b1, 32'h40);

        // ---------------- reset during an outstanding read ---------------
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0); tick();
        obs("midreset", 1'b0, 32'h0, 1'b0, 32'h0);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h0); tick();
        obs("stray_done", 1'b1, 32'h0, 1'b0, 32'h0);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h0); tick();
        obs("restart", 1'b1, 32'h4, 1'b1, 32'h0);

        // ---------------- address wrap-around ----------------------------
        rst_w = 1'b1;
        tick();
        chk("wrap.rd",    rd_w,   1'b1);
        chk("wrap.addr",  addr_w, 32'hFFFF_FFF8);
        chk("wrap.ready", rdy_w,  1'b0);
        tick();
        chk("wrap.pc0",   pc_w,    32'hFFFF_FFF8);
        chk("wrap.ins0",  instr_w, 32'hFFFF_FFF8);
        tick();
        chk("wrap.pc1",   pc_w,    32'hFFFF_FFFC);
        tick();
        chk("wrap.pc2",   pc_w,    32'h0000_0000);
        chk("wrap.ins2",  instr_w, 32'h0000_0000);
        rst_w = 1'b0;

        // ---------------- randomized run vs program-order model ----------
        // Whatever decode consumes must be the architectural sequence:
        // RESET_PC, +4, ... restarting at each redirect target, with data
        // equal to the cache's answer for that PC.
        key = 32'h5A5A_1234;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0); tick(); tick();
        obs("rand_reset", 1'b0, 32'h0, 1'b0, 32'h0);
        exp_pc    = 32'h0;
        prev_rd   = 1'b0;
        prev_done = 1'b0;
        prev_addr = 32'h0;
        consumed  = 0;
        for (int c = 0; c < 3000; c++) begin
            if (prev_rd && !prev_done) begin
                chk("rd_hold",   o_rd,   1'b1);
                chk("addr_hold", o_addr, prev_addr);
            end
            if (!o_rdy) begin
                chk("empty_pc",    o_pc,    32'h0);
                chk("empty_instr", o_instr, 32'h0);
            end
            s = ($urandom % 10) < 3;
            d = $urandom % 2;
            b = ($urandom % 25) == 0;
            t = ($urandom % 4 == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 3) * 4))
                                    : ($urandom & 32'hFFFF_FFFC);
            if (o_rdy && !s && !b) begin
                chk("pc_order",   o_pc,    exp_pc);
                chk("instr_data", o_instr, exp_pc ^ key);
                exp_pc = exp_pc + 32'd4;
                consumed++;
            end
            if (b) begin
                exp_pc = t;
            end
            prev_rd   = o_rd;
            prev_done = d;
            prev_addr = o_addr;
            drive(1'b1, s, d, b, t);
            tick();
        end
        chk("liveness", 64'(consumed >= 200), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_prefetch.md
# fetch_prefetch

Parametrised successor to the single-instruction fetch stage. It decouples the instruction cache from decode through a DEPTH-entry prefetch queue of {pc, instr} pairs and issues sequential cache reads ahead of consumption. It handles redirect (jump/branch) by flushing the queue and discarding any in-flight cache response. It sits between the I-cache and decode in the pipelined core.

## Interface
- ADDRESS_WIDTH, 32, PC / cache address width
- INSTR_WIDTH, 32, instruction width
- DEPTH, 4, prefetch queue entries; power of two, >= 2
- RESET_PC, 0, first fetch address after reset
- i_clk  in  1  clock, all state on rising edge
- i_rst  in  1  reset, synchronous, active-low
- i_stall  in  1  decode not accepting; head not consumed this cycle
- i_branch_taken  in  1  redirect valid (jumps and taken branches)
- i_target_pc  in  ADDRESS_WIDTH  redirect address, sampled when i_branch_taken=1
- i_instr  in  INSTR_WIDTH  cache read data, valid when i_icache_done=1
- i_icache_done  in  1  cache completes current read; ignored unless o_instr_rd=1
- o_instr_rd  out  1  cache read strobe, level, held until done
- o_icache_addr  out  ADDRESS_WIDTH  read address, stable while o_instr_rd=1
- o_instr  out  INSTR_WIDTH  queue head instruction; 0 when empty
- o_pc  out  ADDRESS_WIDTH  queue head PC; 0 when empty
- o_instr_ready  out  1  queue non-empty; head consumed when o_instr_ready & !i_stall

## Operation
- Registers: fetch PC `fpc`, queue (rd/wr pointers, count of width $clog2(DEPTH+1)), FSM.
- FSM states: IDLE (no read outstanding), REQ (read outstanding, response kept), DROP (read outstanding, response to be discarded).
- Issue condition: count (after this cycle's pop/push) < DEPTH; the outstanding read always has a reserved slot, so a push never overflows.
- IDLE -> REQ when the issue condition holds; o_icache_addr <= fpc.
- REQ with done: push {o_icache_addr, i_instr}; fpc advances by 4 (address width wraps modulo 2^ADDRESS_WIDTH). If the issue condition still holds, stay in REQ with the new address (back-to-back); otherwise go to IDLE.
- Redirect (i_branch_taken=1), any state, highest priority:
  - flush the queue (count=0, pointers=0); no pop this cycle; fpc <= i_target_pc.
  - if a read is outstanding and done=0: go to DROP, keep o_instr_rd and the old address until done.
  - if done=1 the same cycle: discard that data; go to REQ at i_target_pc next cycle.
- DROP with done: discard the data, go to REQ at fpc.
- Pop and push in the same cycle are both legal; count is unchanged. When full, a push only happens alongside a pop, because of the slot reservation.
- Reset (i_rst=0), including mid-read: FSM=IDLE, queue empty, fpc=RESET_PC. o_instr_rd=0, o_icache_addr=RESET_PC, o_instr_ready=0, o_instr=0, o_pc=0. A late done after reset is ignored because o_instr_rd=0.

## Timing
- First read: o_instr_rd=1, addr=RESET_PC in the cycle after the first cycle with i_rst=1.
- Done at cycle M -> o_instr_ready=1 with that entry at M+1 (one-cycle queue latency, no bypass).
- Sustained throughput is one instruction per cycle when the cache returns done every cycle and decode does not stall.
- Redirect at cycle R with no outstanding read: read of i_target_pc at R+1. o_instr_ready=0 from R+1 until the target's data is pushed.
- All outputs are registered or driven directly from queue and state registers; there is no combinational path from i_* to o_*.

## Structure
- Package fetch_pkg: FSM enum fetch_state_e {IDLE, REQ, DROP}, INSTR_BYTES=4, queue entry struct {pc, instr}.
- Sub-module fetch_fifo: sync FIFO with flush, parametrised on width and DEPTH, exposing count, empty and full.
- The top level holds the FSM, fpc and slot-reservation logic.

## Test plan
- Reset and stream: cache returns done every cycle with instr = address, no stall. Required: o_pc sequence 0,4,8,12 on consecutive cycles starting 2 cycles after reset release; o_instr equals o_pc.
- Backpressure: i_stall=1 held. Required: exactly DEPTH=4 entries (PCs 0..12) buffered, then o_instr_rd=0. On release, PCs 0,4,8,12,16 appear in order with no loss or duplicate.
- Redirect with read in flight: redirect to 0x100 while the read of 0x8 is outstanding, done 3 cycles later. Required: 0x8 data discarded (DROP), next o_pc=0x100, and no entry from 0x0/0x4 after the redirect.
- Redirect coincident with done: branch to 0x40 in the done cycle. Required: that data is dropped and o_icache_addr=0x40 in the next cycle.
- Mid-read reset: assert i_rst=0 while o_instr_rd=1, then give a done after release. Required: all outputs at reset values, the stray done is ignored, and fetch restarts at RESET_PC.
- Wrap-around: RESET_PC=0xFFFFFFF8. Required: o_pc sequence FFFFFFF8, FFFFFFFC, 00000000.
